// File: rtl/uart_reg_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and reset constants for the UART register bank.
package uart_reg_pkg;

  localparam logic [2:0] REG_TXDATA  = 3'd0;
  localparam logic [2:0] REG_RXDATA  = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_CONTROL = 3'd3;
  localparam logic [2:0] REG_BAUD_LO = 3'd4;
  localparam logic [2:0] REG_BAUD_HI = 3'd5;
  localparam logic [2:0] REG_INT_EN  = 3'd6;
  localparam logic [2:0] REG_SCRATCH = 3'd7;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_NOT_EMPTY = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_TX_OVERFLOW  = 5;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;

  localparam logic [7:0] CONTROL_RESET = 8'h03;
  // Flush bits are pulses, so they never live in the stored CONTROL value.
  localparam logic [7:0] CONTROL_STORE_MASK = 8'hF3;

  function automatic logic [2:0] onehotIndex(input logic [7:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with flush; head data is read combinationally from storage.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         pushData,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/uart_reg_bank.sv
// CPU-visible UART register bank: TX/RX FIFOs, control, baud divisor, interrupt enable and scratch.
module uart_reg_bank
  import uart_reg_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = 16'd325
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  regSelect,
  input  logic        writeStrobe,
  input  logic        readStrobe,
  input  logic [7:0]  dataIn,
  output logic [7:0]  dataOut,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [15:0] baudDivisor,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic       selValid;
  logic [2:0] selIndex;
  logic       wrEn;
  logic       rdEn;

  logic [7:0] control;
  logic [7:0] baudLo;
  logic [7:0] baudHi;
  logic [7:0] intEn;
  logic [7:0] scratch;
  logic       rxOverrun;
  logic       txOverflow;

  logic          txPush, txPop, txFlush, txFull, txEmpty;
  logic          rxPush, rxPop, rxFlush, rxFull, rxEmpty;
  logic [7:0]    rxHead;
  logic [CW-1:0] txCount;
  logic [CW-1:0] rxCount;
  logic          unusedCounts;

  logic       statusClear;
  logic       setOverrun;
  logic       setOverflow;
  logic [7:0] status;
  logic [7:0] readValue;

  // A select with zero or several bits set is treated as no access at all.
  assign selValid = (regSelect != 8'h00) && ((regSelect & (regSelect - 8'd1)) == 8'h00);
  assign selIndex = onehotIndex(regSelect);
  assign wrEn     = writeStrobe && selValid;
  assign rdEn     = readStrobe && !writeStrobe && selValid;

  assign txValid = !txEmpty && control[CTRL_TX_EN];
  assign txPush  = wrEn && (selIndex == REG_TXDATA);
  assign txPop   = txValid && txReady;
  assign txFlush = wrEn && (selIndex == REG_CONTROL) && dataIn[CTRL_TX_FLUSH];

  assign rxPush  = rxValid && control[CTRL_RX_EN];
  assign rxPop   = rdEn && (selIndex == REG_RXDATA);
  assign rxFlush = wrEn && (selIndex == REG_CONTROL) && dataIn[CTRL_RX_FLUSH];

  assign unusedCounts = ^{txCount, rxCount};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk(clk), .reset(reset), .push(txPush), .pop(txPop), .flush(txFlush),
    .pushData(dataIn), .headData(txData), .full(txFull), .empty(txEmpty), .count(txCount)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk(clk), .reset(reset), .push(rxPush), .pop(rxPop), .flush(rxFlush),
    .pushData(rxData), .headData(rxHead), .full(rxFull), .empty(rxEmpty), .count(rxCount)
  );

  assign statusClear = rdEn && (selIndex == REG_STATUS);
  assign setOverrun  = rxPush && rxFull && !rxPop;
  assign setOverflow = txPush && txFull && !txPop;

  always_comb begin
    status                  = 8'h00;
    status[ST_TX_FULL]      = txFull;
    status[ST_TX_EMPTY]     = txEmpty;
    status[ST_RX_NOT_EMPTY] = !rxEmpty;
    status[ST_RX_FULL]      = rxFull;
    status[ST_RX_OVERRUN]   = rxOverrun;
    status[ST_TX_OVERFLOW]  = txOverflow;
  end

  always_comb begin
    readValue = 8'h00;
    case (selIndex)
      REG_RXDATA:  readValue = rxEmpty ? 8'h00 : rxHead;
      REG_STATUS:  readValue = status;
      REG_CONTROL: readValue = control;
      REG_BAUD_LO: readValue = baudLo;
      REG_BAUD_HI: readValue = baudHi;
      REG_INT_EN:  readValue = intEn;
      REG_SCRATCH: readValue = scratch;
      default:     readValue = 8'h00;
    endcase
  end

  // A sticky flag set in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      control    <= CONTROL_RESET;
      baudLo     <= BAUD_RESET[7:0];
      baudHi     <= BAUD_RESET[15:8];
      intEn      <= 8'h00;
      scratch    <= 8'h00;
      rxOverrun  <= 1'b0;
      txOverflow <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rxOverrun  <= setOverrun  || (rxOverrun  && !statusClear);
      txOverflow <= setOverflow || (txOverflow && !statusClear);
      irq        <= |(intEn[2:0] & {rxOverrun, txEmpty, !rxEmpty});
      if (wrEn) begin
        case (selIndex)
          REG_CONTROL: control <= dataIn & CONTROL_STORE_MASK;
          REG_BAUD_LO: baudLo  <= dataIn;
          REG_BAUD_HI: baudHi  <= dataIn;
          REG_INT_EN:  intEn   <= dataIn;
          REG_SCRATCH: scratch <= dataIn;
          default:     ;
        endcase
      end
    end
  end

  // Rejected accesses (bad select, read-only target, read-with-write) drive zero onto dataOut.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= 8'h00;
    end else if (readStrobe) begin
      dataOut <= rdEn ? readValue : 8'h00;
    end else if (writeStrobe &&
                 (!selValid || selIndex == REG_RXDATA || selIndex == REG_STATUS)) begin
      dataOut <= 8'h00;
    end
  end

  assign baudDivisor = {baudHi, baudLo};

endmodule
